aes_decipher_first_block: RTL and testbench



---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_inv_shiftrows.sv | 14 +
 rtl/aes_decipher_first_block.sv | 100 ++++++++++
 tb/tb_aes_decipher_first_block.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the decipher chain.
//   BLOCK_W        : state width in bits (128)
//   NB             : number of state bytes (16)
//   inv_shift_rows : byte permutation used by every decipher round;
//                    state is column-major, byte 0 = [127:120]
package aes_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned NB      = 16;

    // out[r+4c] = in[r+4((c-r) mod 4)]: row r rotates right by r.
    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] state);
        logic [BLOCK_W-1:0] result;
        result = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                result[BLOCK_W-1-8*(r+4*c) -: 8] =
                    state[BLOCK_W-1-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/aes_inv_shiftrows.sv
// Combinational AES InvShiftRows on a 128-bit column-major state.
// Ports:
//   state   in  128  state before permutation
//   shifted out 128  state after InvShiftRows
module aes_inv_shiftrows
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    output logic [BLOCK_W-1:0] shifted
);

    assign shifted = inv_shift_rows(state);

endmodule

// File: rtl/aes_decipher_first_block.sv
// First AES-128 decipher round: AddRoundKey(round-10 key), InvShiftRows,
// InvSubBytes (inverse S-box lookup is external, via old/new_inv_sbox).
// Valid/ready pipeline with backpressure, strict FIFO order.
// Ports:
//   clk, reset_n       clock; synchronous active-low reset
//   round_key          round-10 key, sampled with in_block on accept
//   in_valid/in_ready  upstream handshake; accept when both high
//   in_block           ciphertext, byte0 = [127:120]
//   old_inv_sbox       bytes sent to the external inverse S-box (stage 2 data)
//   new_inv_sbox       external inverse S-box result, same cycle
//   out_valid/out_ready downstream handshake
//   out_block          InvSubBytes(InvShiftRows(in_block ^ round_key))
// Parameters:
//   BLOCK_W   must be 128
//   REG_SBOX  1: registered S-box stage (latency 3); 0: combinational (latency 2)
module aes_decipher_first_block #(
    parameter int unsigned BLOCK_W  = 128,
    parameter bit          REG_SBOX = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_block,
    output logic [BLOCK_W-1:0] old_inv_sbox,
    input  logic [BLOCK_W-1:0] new_inv_sbox,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block
);
    import aes_pkg::*;

    if (BLOCK_W != aes_pkg::BLOCK_W) begin : g_width_check
        $error("aes_decipher_first_block: BLOCK_W must be 128");
    end

    logic               v1, v2;
    logic [BLOCK_W-1:0] s1, s2;
    logic [BLOCK_W-1:0] s1_shifted;
    logic               adv1, adv2;

    aes_inv_shiftrows u_inv_shiftrows (
        .state   (s1),
        .shifted (s1_shifted)
    );

    // A stage may load when it is empty or the stage after it is moving.
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    assign old_inv_sbox = s2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v1 <= 1'b0;
            s1 <= '0;
            v2 <= 1'b0;
            s2 <= '0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1 <= in_block ^ round_key;
                end
            end
            if (adv2) begin
                v2 <= v1;
                s2 <= s1_shifted;
            end
        end
    end

    if (REG_SBOX) begin : g_reg_sbox
        logic               v3;
        logic [BLOCK_W-1:0] s3;
        logic               adv3;

        assign adv3 = !v3 || out_ready;
        assign adv2 = !v2 || adv3;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                v3 <= 1'b0;
                s3 <= '0;
            end else if (adv3) begin
                v3 <= v2;
                s3 <= new_inv_sbox;
            end
        end

        assign out_valid = v3;
        assign out_block = s3;
    end else begin : g_comb_sbox
        assign adv2      = !v2 || out_ready;
        assign out_valid = v2;
        assign out_block = new_inv_sbox;
    end

endmodule

// File: tb/tb_aes_decipher_first_block.sv
module tb_aes_decipher_first_block;

    localparam logic [2047:0] ISBOX = 2048'h52096ad53036a538bf40a39e81f3d7fb_7ce339829b2fff87348e4344c4dee9cb_547b9432a6c2233dee4c950b42fac34e_082ea16628d924b2765ba2496d8bd125_72f8f66486689816d4a45ccc5d65b692_6c704850fdedb9da5e154657a78d9d84_90d8ab008cbcd30af7e45805b8b34506_d02c1e8fca3f0f02c1afbd0301138a6b_3a9111414f67dcea97f2cfcef0b4e673_96ac7422e7ad3585e2f937e81c75df6e_47f11a711d29c5896fb7620eaa18be1b_fc563e4bc6d279209adbc0fe78cd5af4_1fdda8338807c731b11210592780ec5f_60517fa919b54a0d2de57a9f93c99cef_a0e03b4dae2af5b0c8ebbb3c83539961_172b047eba77d626e169146355210c7d;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, in_valid, out_ready;
    logic [127:0] in_block, round_key;

    logic         in_ready1, out_valid1;
    logic [127:0] old1, new1, out1;
    logic         in_ready0, out_valid0;
    logic [127:0] old0, new0, out0;

    int passed = 0;
    int total  = 0;

    function automatic logic [7:0] inv_sbox_byte(input logic [7:0] b);
        int idx;
        idx = int'(b);
        return ISBOX[2047-8*idx -: 8];
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[127-8*i -: 8] = inv_sbox_byte(x[127-8*i -: 8]);
        return y;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] blk, input logic [127:0] key);
        logic [7:0]   st [4][4];
        logic [127:0] x, res;
        x = blk ^ key;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) st[r][c] = x[127-8*(4*c+r) -: 8];
        res = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) res[127-8*(4*c+r) -: 8] = st[r][(c+4-r)%4];
        return inv_sub_bytes(res);
    endfunction

    always_comb new1 = inv_sub_bytes(old1);
    always_comb new0 = inv_sub_bytes(old0);

    aes_decipher_first_block #(.BLOCK_W(128), .REG_SBOX(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .round_key(round_key),
        .in_valid(in_valid), .in_ready(in_ready1), .in_block(in_block),
        .old_inv_sbox(old1), .new_inv_sbox(new1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_block(out1)
    );

    aes_decipher_first_block #(.BLOCK_W(128), .REG_SBOX(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .round_key(round_key),
        .in_valid(in_valid), .in_ready(in_ready0), .in_block(in_block),
        .old_inv_sbox(old0), .new_inv_sbox(new0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_block(out0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_block = '0; round_key = '0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_block = '0; round_key = '0;
        tick(); tick();
        reset_n = 1'b1;
        @(negedge clk);
        total++; if ({in_ready1, out_valid1} !== 2'b10) $display("FAIL reset_hs3: got ready=%b valid=%b want 1/0", in_ready1, out_valid1); else passed++;
        total++; if (out1 !== 128'h0) $display("FAIL reset_out3: got %h want 0", out1); else passed++;
        total++; if (old1 !== 128'h0 || old0 !== 128'h0) $display("FAIL reset_old: got %h / %h want 0", old1, old0); else passed++;
        total++; if ({in_ready0, out_valid0} !== 2'b10) $display("FAIL reset_hs2: got ready=%b valid=%b want 1/0", in_ready0, out_valid0); else passed++;
    endtask

    task automatic test_fips();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            in_valid  = (i == 0);
            in_block  = 128'h3925841d02dc09fbdc118597196a0b32;
            round_key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            @(negedge clk);
            if (i == 0) begin
                total++; if (in_ready1 !== 1'b1) $display("FAIL fips_in_ready: got %b want 1", in_ready1); else passed++;
            end
            if (i == 2) begin
                total++; if (old1 !== 128'he9098972cb31075f3d327d94af2e2cb5) $display("FAIL fips_old3: got %h want e9098972cb31075f3d327d94af2e2cb5", old1); else passed++;
                total++; if (old0 !== 128'he9098972cb31075f3d327d94af2e2cb5) $display("FAIL fips_old2: got %h want e9098972cb31075f3d327d94af2e2cb5", old0); else passed++;
                total++; if (out_valid1 !== 1'b0) $display("FAIL fips_early3: got valid %b want 0", out_valid1); else passed++;
                total++; if ({out_valid0, out0} !== {1'b1, 128'heb40f21e592e38848ba113e71bc342d2}) $display("FAIL fips_out2: got %b %h want 1 eb40f21e592e38848ba113e71bc342d2", out_valid0, out0); else passed++;
            end
            if (i == 3) begin
                total++; if ({out_valid1, out1} !== {1'b1, 128'heb40f21e592e38848ba113e71bc342d2}) $display("FAIL fips_out3: got %b %h want 1 eb40f21e592e38848ba113e71bc342d2", out_valid1, out1); else passed++;
            end
        end
    endtask

    task automatic test_zero();
        do_reset();
        total++; if (model('0, '0) !== {16{8'h52}}) $display("FAIL zero_model: got %h want 5252..52", model('0, '0)); else passed++;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            in_valid = (i == 0); in_block = '0; round_key = '0;
            @(negedge clk);
            if (i == 2) begin
                total++; if ({out_valid0, out0} !== {1'b1, {16{8'h52}}}) $display("FAIL zero_out2: got %b %h want 1 5252..52", out_valid0, out0); else passed++;
            end
            if (i == 3) begin
                total++; if ({out_valid1, out1} !== {1'b1, {16{8'h52}}}) $display("FAIL zero_out3: got %b %h want 1 5252..52", out_valid1, out1); else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] vec [4];
        logic [127:0] key;
        vec[0] = 128'h00112233445566778899aabbccddeeff;
        vec[1] = 128'h0123456789abcdeffedcba9876543210;
        vec[2] = 128'hdeadbeefcafef00d0badf00d12345678;
        vec[3] = 128'hffffffffffffffffffffffffffffffff;
        key    = 128'h000102030405060708090a0b0c0d0e0f;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            in_valid = (i < 4); in_block = vec[i%4]; round_key = key;
            @(negedge clk);
            if (i < 4) begin
                total++; if ({in_ready1, in_ready0} !== 2'b11) $display("FAIL b2b_in_ready c%0d: got %b%b want 11", i, in_ready1, in_ready0); else passed++;
            end
            total++; if (out_valid1 !== (i >= 3 && i <= 6)) $display("FAIL b2b_valid3 c%0d: got %b want %b", i, out_valid1, (i >= 3 && i <= 6)); else passed++;
            if (i >= 3 && i <= 6) begin
                total++; if (out1 !== model(vec[i-3], key)) $display("FAIL b2b_out3 c%0d: got %h want %h", i, out1, model(vec[i-3], key)); else passed++;
            end
            total++; if (out_valid0 !== (i >= 2 && i <= 5)) $display("FAIL b2b_valid2 c%0d: got %b want %b", i, out_valid0, (i >= 2 && i <= 5)); else passed++;
            if (i >= 2 && i <= 5) begin
                total++; if (out0 !== model(vec[i-2], key)) $display("FAIL b2b_out2 c%0d: got %h want %h", i, out0, model(vec[i-2], key)); else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] vec [5];
        logic [127:0] key;
        logic [127:0] exp_q [$];
        logic [127:0] expv;
        int idx, nout;
        for (int k = 0; k < 5; k++) vec[k] = {4{32'h10203040 + 32'(k) * 32'h01010101}};
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        idx = 0; nout = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            out_ready = (i >= 6);
            in_valid  = (idx < 5);
            in_block  = vec[(idx < 5) ? idx : 4];
            round_key = key;
            @(negedge clk);
            if (i == 3) begin
                total++; if (idx !== 3) $display("FAIL bp_accepts: got %0d want 3", idx); else passed++;
            end
            if (i >= 3 && i <= 5) begin
                total++; if (in_ready1 !== 1'b0) $display("FAIL bp_in_ready c%0d: got %b want 0", i, in_ready1); else passed++;
                total++; if ({out_valid1, out1} !== {1'b1, model(vec[0], key)}) $display("FAIL bp_hold c%0d: got %b %h want 1 %h", i, out_valid1, out1, model(vec[0], key)); else passed++;
            end
            if (out_valid1 && out_ready) begin
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                total++; if (out1 !== expv) $display("FAIL bp_order #%0d: got %h want %h", nout, out1, expv); else passed++;
                nout++;
            end
            if (in_valid && in_ready1) begin
                exp_q.push_back(model(vec[idx], key));
                idx++;
            end
        end
        total++; if (nout !== 5 || exp_q.size() !== 0) $display("FAIL bp_count: got %0d outputs, %0d pending want 5, 0", nout, exp_q.size()); else passed++;
    endtask

    task automatic test_key_change();
        logic [127:0] blk, k1, want;
        blk  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        k1   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        want = model(blk, k1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            in_valid  = (i == 0);
            in_block  = blk;
            round_key = (i == 0) ? k1 : ~k1;
            @(negedge clk);
            if (i == 2) begin
                total++; if ({out_valid0, out0} !== {1'b1, want}) $display("FAIL key_out2: got %b %h want 1 %h", out_valid0, out0, want); else passed++;
            end
            if (i == 3) begin
                total++; if ({out_valid1, out1} !== {1'b1, want}) $display("FAIL key_out3: got %b %h want 1 %h", out_valid1, out1, want); else passed++;
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            in_valid  = (i < 2);
            in_block  = 128'h3925841d02dc09fbdc118597196a0b32 ^ 128'(i);
            round_key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            reset_n   = (i != 2);
        end
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        total++; if ({out_valid1, out1} !== {1'b0, 128'h0}) $display("FAIL midrst_out: got %b %h want 0 0", out_valid1, out1); else passed++;
        total++; if (old1 !== 128'h0) $display("FAIL midrst_old: got %h want 0", old1); else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            total++; if ({out_valid1, out_valid0} !== 2'b00) $display("FAIL midrst_stale c%0d: got %b%b want 00", i, out_valid1, out_valid0); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_zero();
        test_back_to_back();
        test_backpressure();
        test_key_change();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
